t03_mem_arbiter: RTL and testbench

Two-requester memory arbiter between the CPU instruction-fetch port and the CPU data (load/store/MMIO) port, driving the single shared memory/bus port. Requests are latched at grant, issued downstream until acknowledged, and returned to the granted requester with a one-cycle ack. Ties are resolved round-robin. A watchdog aborts any bus transaction that hangs.

---
 rtl/t03_arb_pkg.sv | 31 +++
 rtl/t03_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_t03_mem_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/t03_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package t03_arb_pkg;

    localparam int unsigned ADR_W  = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned WDOG_W = 8;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam logic [SEL_W-1:0]  SEL_ALL          = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_INSTR = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    // Downstream request latched at grant time
    typedef struct packed {
        logic              write;
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] wdata;
        logic [SEL_W-1:0]  sel;
    } mem_req_t;

endpackage

// File: rtl/t03_mem_arbiter.sv
// Round-robin arbiter between instruction-fetch and data ports onto one
// shared memory port, with a watchdog that aborts hung transactions.
module t03_mem_arbiter
    import t03_arb_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_req,
    input  logic [ADR_W-1:0]  i_adr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADR_W-1:0]  d_adr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [SEL_W-1:0]  d_sel,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADR_W-1:0]  mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [SEL_W-1:0]  mem_sel,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              timeout_err
);

    localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(TIMEOUT_CYCLES);

    state_t              state_q,       state_d;
    grant_t              last_grant_q,  last_grant_d;
    grant_t              gnt_q,         gnt_d;
    mem_req_t            req_q,         req_d;
    logic [WDOG_W-1:0]   wdog_q,        wdog_d;
    logic                mem_read_q,    mem_read_d;
    logic                mem_write_q,   mem_write_d;
    logic                i_ack_q,       i_ack_d;
    logic                d_ack_q,       d_ack_d;
    logic [DATA_W-1:0]   i_rdata_q,     i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q,     d_rdata_d;
    logic                timeout_err_q, timeout_err_d;

    logic                d_act_c;
    logic                pick_data_c;
    logic                pick_instr_c;
    logic [WDOG_W-1:0]   wdog_inc_c;
    logic                complete_c;
    logic [DATA_W-1:0]   cap_c;

    // Round-robin pick: on a tie, the side that did not win last time
    always_comb begin
        d_act_c      = d_read | d_write;
        pick_data_c  = d_act_c && (!i_req || (last_grant_q == GNT_INSTR));
        pick_instr_c = i_req && !pick_data_c;
        wdog_inc_c   = wdog_q + WDOG_W'(1);
    end

    // Next-state, latched request, watchdog and response generation
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        gnt_d         = gnt_q;
        req_d         = req_q;
        wdog_d        = wdog_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        i_ack_d       = 1'b0;
        d_ack_d       = 1'b0;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        timeout_err_d = 1'b0;
        complete_c    = 1'b0;
        cap_c         = '0;

        case (state_q)
            IDLE: begin
                if (pick_data_c) begin
                    // Simultaneous read+write is treated as a write
                    req_d.write  = d_write;
                    req_d.adr    = d_adr;
                    req_d.wdata  = d_wdata;
                    req_d.sel    = d_sel;
                    gnt_d        = GNT_DATA;
                    last_grant_d = GNT_DATA;
                    wdog_d       = '0;
                    mem_read_d   = !d_write;
                    mem_write_d  = d_write;
                    state_d      = ISSUE;
                end else if (pick_instr_c) begin
                    req_d.write  = 1'b0;
                    req_d.adr    = i_adr;
                    req_d.wdata  = '0;
                    req_d.sel    = SEL_ALL;
                    gnt_d        = GNT_INSTR;
                    last_grant_d = GNT_INSTR;
                    wdog_d       = '0;
                    mem_read_d   = 1'b1;
                    state_d      = ISSUE;
                end
            end

            ISSUE: begin
                if (mem_ack) begin
                    // A real ack beats a watchdog expiring in the same cycle
                    complete_c = 1'b1;
                    cap_c      = mem_rdata;
                    state_d    = RESP;
                end else if (wdog_inc_c == WDOG_LIM) begin
                    complete_c    = 1'b1;
                    cap_c         = ERR_DATA;
                    timeout_err_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    wdog_d      = wdog_inc_c;
                    mem_read_d  = !req_q.write;
                    mem_write_d = req_q.write;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Route the captured data and the one-cycle ack to the granted side
        if (complete_c) begin
            if (gnt_q == GNT_DATA) begin
                d_rdata_d = cap_c;
                d_ack_d   = 1'b1;
            end else begin
                i_rdata_d = cap_c;
                i_ack_d   = 1'b1;
            end
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q       <= IDLE;
            last_grant_q  <= GNT_INSTR;
            gnt_q         <= GNT_INSTR;
            req_q         <= '0;
            wdog_q        <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            i_ack_q       <= 1'b0;
            d_ack_q       <= 1'b0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            gnt_q         <= gnt_d;
            req_q         <= req_d;
            wdog_q        <= wdog_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            i_ack_q       <= i_ack_d;
            d_ack_q       <= d_ack_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_adr     = req_q.adr;
    assign mem_wdata   = req_q.wdata;
    assign mem_sel     = req_q.sel;
    assign i_ack       = i_ack_q;
    assign d_ack       = d_ack_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_t03_mem_arbiter.sv
// Directed self-checking bench for t03_mem_arbiter (watchdog limit 4).
module tb_t03_mem_arbiter;

    logic        clk;
    logic        nrst;
    logic        i_req;
    logic [31:0] i_adr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_adr;
    logic [31:0] d_wdata;
    logic [3:0]  d_sel;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    // {mem_read, i_ack, d_ack} per cycle while both sides request continuously
    logic [2:0]  tie_exp [9] = '{3'b100, 3'b001, 3'b000,
                                 3'b100, 3'b010, 3'b000,
                                 3'b100, 3'b001, 3'b000};
    logic [31:0] tie_adr [9] = '{32'h0000_2000, 32'h0, 32'h0,
                                 32'h0000_1000, 32'h0, 32'h0,
                                 32'h0000_2000, 32'h0, 32'h0};

    t03_mem_arbiter #(
        .TIMEOUT_CYCLES (4),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .i_req       (i_req),
        .i_adr       (i_adr),
        .i_rdata     (i_rdata),
        .i_ack       (i_ack),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_adr       (d_adr),
        .d_wdata     (d_wdata),
        .d_sel       (d_sel),
        .d_rdata     (d_rdata),
        .d_ack       (d_ack),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_adr     (mem_adr),
        .mem_wdata   (mem_wdata),
        .mem_sel     (mem_sel),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        nrst = 1'b0; i_req = 1'b0; i_adr = '0; d_read = 1'b0; d_write = 1'b0;
        d_adr = '0; d_wdata = '0; d_sel = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick(); tick();
        nrst = 1'b1;

        // Reset state
        chk("rst_outs", {28'(0), mem_read, mem_write, i_ack, d_ack}, 32'h0);
        chk("rst_terr", 32'(timeout_err), 32'h0);
        chk("rst_irdata", i_rdata, 32'h0);
        chk("rst_drdata", d_rdata, 32'h0);
        chk("rst_madr", mem_adr, 32'h0);

        // Fetch only, mem_ack one cycle after the strobe
        i_req = 1'b1; i_adr = 32'h0000_0100;
        tick();
        chk("f_rd", {31'(0), mem_read}, 32'h1);
        chk("f_wr", {31'(0), mem_write}, 32'h0);
        chk("f_adr", mem_adr, 32'h0000_0100);
        chk("f_sel", {28'(0), mem_sel}, 32'hF);
        tick();
        chk("f_rd_hold", {31'(0), mem_read}, 32'h1);
        chk("f_iack_early", {31'(0), i_ack}, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        tick();
        chk("f_iack", {31'(0), i_ack}, 32'h1);
        chk("f_irdata", i_rdata, 32'h0050_0093);
        chk("f_dack", {31'(0), d_ack}, 32'h0);
        chk("f_rd_drop", {31'(0), mem_read}, 32'h0);
        mem_ack = 1'b0; i_req = 1'b0;
        tick();
        chk("f_iack_once", {31'(0), i_ack}, 32'h0);
        chk("f_irdata_hold", i_rdata, 32'h0050_0093);

        // Write; live inputs change mid-ISSUE to prove the latched copy is used
        d_write = 1'b1; d_adr = 32'hFFFF_0004; d_wdata = 32'h0000_0003; d_sel = 4'b0011;
        tick();
        chk("w_wr", {31'(0), mem_write}, 32'h1);
        chk("w_rd", {31'(0), mem_read}, 32'h0);
        chk("w_adr", mem_adr, 32'hFFFF_0004);
        chk("w_wdata", mem_wdata, 32'h0000_0003);
        chk("w_sel", {28'(0), mem_sel}, 32'h3);
        d_adr = 32'h1234_5678; d_wdata = 32'hCAFE_F00D; d_sel = 4'hC;
        tick();
        chk("w_adr_latched", mem_adr, 32'hFFFF_0004);
        chk("w_wdata_latched", mem_wdata, 32'h0000_0003);
        chk("w_sel_latched", {28'(0), mem_sel}, 32'h3);
        mem_ack = 1'b1;
        tick();
        chk("w_dack", {30'(0), i_ack, d_ack}, 32'h1);
        chk("w_wr_drop", {31'(0), mem_write}, 32'h0);
        mem_ack = 1'b0; d_write = 1'b0;
        tick();
        chk("w_dack_once", {31'(0), d_ack}, 32'h0);

        // Tie after reset, both held, zero-wait memory: D, I, D
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        i_req = 1'b1; i_adr = 32'h0000_1000;
        d_read = 1'b1; d_adr = 32'h0000_2000;
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        for (int t = 0; t < 9; t++) begin
            tick();
            chk($sformatf("tie_c%0d", t), {29'(0), mem_read, i_ack, d_ack}, {29'(0), tie_exp[t]});
            if (tie_exp[t][2]) chk($sformatf("tie_adr%0d", t), mem_adr, tie_adr[t]);
            if (t == 7) begin
                i_req = 1'b0; d_read = 1'b0;
            end
        end
        chk("tie_drdata", d_rdata, 32'h0BAD_F00D);
        chk("tie_irdata", i_rdata, 32'h0BAD_F00D);
        mem_ack = 1'b0;

        // Watchdog abort with limit 4
        d_read = 1'b1; d_adr = 32'h0000_0040;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk($sformatf("to_rd%0d", t), {30'(0), mem_read, timeout_err}, 32'h2);
        end
        tick();
        chk("to_dack", {31'(0), d_ack}, 32'h1);
        chk("to_err", {31'(0), timeout_err}, 32'h1);
        chk("to_drdata", d_rdata, 32'hDEAD_BEEF);
        chk("to_rd_drop", {31'(0), mem_read}, 32'h0);
        d_read = 1'b0;
        tick();
        chk("to_err_once", {30'(0), timeout_err, d_ack}, 32'h0);

        // mem_ack arriving in the last watchdog cycle wins
        d_read = 1'b1; d_adr = 32'h0000_0080;
        tick(); tick(); tick(); tick();
        chk("tb_rd_c4", {31'(0), mem_read}, 32'h1);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        chk("tb_dack", {31'(0), d_ack}, 32'h1);
        chk("tb_noerr", {31'(0), timeout_err}, 32'h0);
        chk("tb_drdata", d_rdata, 32'h1234_5678);
        mem_ack = 1'b0; d_read = 1'b0;
        tick();

        // Reset mid-ISSUE, then a late mem_ack is ignored
        i_req = 1'b1; i_adr = 32'h0000_0300;
        tick();
        chk("mr_rd", {31'(0), mem_read}, 32'h1);
        nrst = 1'b0;
        tick();
        chk("mr_rd_rst", {30'(0), mem_read, i_ack}, 32'h0);
        nrst = 1'b1; i_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        chk("mr_late_ack", {29'(0), mem_read, i_ack, d_ack}, 32'h0);
        mem_ack = 1'b0;
        tick();
        chk("mr_quiet", {29'(0), mem_read, i_ack, d_ack}, 32'h0);

        // Next fetch completes with zero-wait ack: ack 2 cycles after sampling
        i_req = 1'b1; i_adr = 32'h0000_0200;
        tick();
        chk("zw_adr", mem_adr, 32'h0000_0200);
        chk("zw_iack_c1", {31'(0), i_ack}, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_0001;
        tick();
        chk("zw_iack", {31'(0), i_ack}, 32'h1);
        chk("zw_irdata", i_rdata, 32'hA5A5_0001);
        mem_ack = 1'b0; i_req = 1'b0;
        tick();
        chk("zw_idle", {29'(0), mem_read, i_ack, d_ack}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
